// File: rtl/crg_ctrl_pkg.sv
// Shared types for the clock-generation sequencer: FSM states, clk1/clk3
// configuration record and its power-on value.
package crg_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_IDLE      = 3'd2,
    ST_GATE      = 3'd3,
    ST_SWITCH    = 3'd4,
    ST_UNGATE    = 3'd5
  } state_t;

  typedef struct packed {
    logic sel;
    logic clk1_on;
    logic clk3_on;
  } clk_cfg_t;

  localparam clk_cfg_t CFG_RESET = 3'b000;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/crg_lock_filter.sv
// PLL lock qualification: 2-FF synchronizer followed by a consecutive-high
// counter. The counter only runs while enabled, so it restarts from zero on
// every entry into lock waiting.
module crg_lock_filter #(
  parameter int LOCK_FILTER = 32
) (
  input  logic clk_src,
  input  logic rst_n_sys,
  input  logic pll_locked,
  input  logic enable,
  output logic lock_sync,
  output logic locked_q
);

  localparam int CW = $clog2(LOCK_FILTER + 1);
  localparam logic [CW-1:0] FILTER_FULL = CW'(LOCK_FILTER);

  logic          sync_ff1;
  logic [CW-1:0] cnt;

  // Bring the asynchronous lock into the clk_src domain.
  always_ff @(posedge clk_src) begin
    if (!rst_n_sys) begin
      sync_ff1  <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      sync_ff1  <= pll_locked;
      lock_sync <= sync_ff1;
    end
  end

  // Count consecutive synchronized-high cycles; any low restarts the count.
  always_ff @(posedge clk_src) begin
    if (!rst_n_sys || !enable || !lock_sync) begin
      cnt <= '0;
    end else if (cnt != FILTER_FULL) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign locked_q = (cnt == FILTER_FULL);

endmodule

// File: rtl/crg_clk_ctrl.sv
// Clock-generation sequencer: PLL reset and lock qualification, then
// glitch-safe clk1 source switching (gate -> switch -> ungate) and clk1/clk3
// gate control driven by a single request handshake.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   PLL_RST   | pll_reset held high for PLL_RST_CYC cycles
//   WAIT_LOCK | waiting for LOCK_FILTER consecutive synchronized-lock highs
//   IDLE      | configured; req_ready high
//   GATE      | clk1 gated, waiting GATE_WAIT before moving the mux
//   SWITCH    | clk1_sel moved, waiting SWITCH_WAIT before ungating
//   UNGATE    | apply pending enables, commit config, pulse done
module crg_clk_ctrl
  import crg_ctrl_pkg::*;
#(
  parameter int PLL_RST_CYC = 16,
  parameter int LOCK_FILTER = 32,
  parameter int GATE_WAIT   = 8,
  parameter int SWITCH_WAIT = 16
) (
  input  logic clk_src,
  input  logic rst_n_sys,
  input  logic pll_locked,
  output logic pll_reset,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_sel,
  input  logic req_clk1_on,
  input  logic req_clk3_on,
  output logic clk1_sel,
  output logic clk1_en,
  output logic clk3_en,
  output logic busy,
  output logic done,
  output logic lock_lost
);

  localparam int CW = $clog2(max_of4(PLL_RST_CYC, LOCK_FILTER, GATE_WAIT, SWITCH_WAIT) + 1);
  localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYC - 1);
  localparam logic [CW-1:0] GATE_LAST   = CW'(GATE_WAIT - 1);
  localparam logic [CW-1:0] SWITCH_LAST = CW'(SWITCH_WAIT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  clk_cfg_t      pending, committed;
  logic          lock_sync, locked_q;
  logic          accept, loss, counting;

  crg_lock_filter #(.LOCK_FILTER(LOCK_FILTER)) u_lock_filter (
    .clk_src    (clk_src),
    .rst_n_sys  (rst_n_sys),
    .pll_locked (pll_locked),
    .enable     (state == ST_WAIT_LOCK),
    .lock_sync  (lock_sync),
    .locked_q   (locked_q)
  );

  assign accept   = req_valid && req_ready && (state == ST_IDLE);
  assign loss     = !lock_sync && (state inside {ST_IDLE, ST_GATE, ST_SWITCH, ST_UNGATE});
  assign counting = (state inside {ST_PLL_RST, ST_GATE, ST_SWITCH});

  // Next-state decode; lock loss overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (loss) begin
      state_nxt = ST_PLL_RST;
    end else begin
      case (state)
        ST_PLL_RST:   if (cnt == RST_LAST) state_nxt = ST_WAIT_LOCK;
        ST_WAIT_LOCK: if (locked_q) state_nxt = ST_UNGATE;
        ST_IDLE:      if (accept) state_nxt = (req_sel == committed.sel) ? ST_UNGATE : ST_GATE;
        ST_GATE:      if (cnt == GATE_LAST) state_nxt = ST_SWITCH;
        ST_SWITCH:    if (cnt == SWITCH_LAST) state_nxt = ST_UNGATE;
        ST_UNGATE:    state_nxt = ST_IDLE;
        default:      state_nxt = ST_PLL_RST;
      endcase
    end
  end

  // State, wait counter, config records and all registered outputs.
  always_ff @(posedge clk_src) begin
    if (!rst_n_sys) begin
      state     <= ST_PLL_RST;
      cnt       <= '0;
      pending   <= CFG_RESET;
      committed <= CFG_RESET;
      pll_reset <= 1'b1;
      clk1_sel  <= 1'b0;
      clk1_en   <= 1'b0;
      clk3_en   <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b1;
      done      <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= (state_nxt != state || !counting) ? '0 : cnt + 1'b1;
      pll_reset <= (state_nxt == ST_PLL_RST);
      busy      <= (state_nxt != ST_IDLE);
      req_ready <= (state == ST_IDLE) && (state_nxt == ST_IDLE);
      done      <= 1'b0;
      if (loss) begin
        clk1_en   <= 1'b0;
        clk3_en   <= 1'b0;
        lock_lost <= 1'b1;
      end else begin
        case (state)
          // Both gates are off here, so the mux can safely be put back to
          // the committed source before the restore ungates.
          ST_WAIT_LOCK: if (locked_q) begin
            pending  <= committed;
            clk1_sel <= committed.sel;
          end
          ST_IDLE:   if (accept) pending <= {req_sel, req_clk1_on, req_clk3_on};
          ST_GATE:   clk1_en <= 1'b0;
          ST_SWITCH: clk1_sel <= pending.sel;
          ST_UNGATE: begin
            clk1_en   <= pending.clk1_on;
            clk3_en   <= pending.clk3_on;
            committed <= pending;
            done      <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crg_clk_ctrl.sv
// Self-checking bench for crg_clk_ctrl: each done pulse is matched against a
// scoreboard entry of the expected {clk1_sel, clk1_en, clk3_en}.
module tb_crg_clk_ctrl;

  logic clk_src = 1'b0;
  logic rst_n_sys = 1'b0;
  logic pll_locked = 1'b0;
  logic req_valid = 1'b0;
  logic req_sel = 1'b0;
  logic req_clk1_on = 1'b0;
  logic req_clk3_on = 1'b0;
  logic pll_reset, req_ready, clk1_sel, clk1_en, clk3_en, busy, done, lock_lost;

  typedef struct packed {
    logic sel;
    logic en1;
    logic en3;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk_src = ~clk_src;

  crg_clk_ctrl dut (
    .clk_src     (clk_src),
    .rst_n_sys   (rst_n_sys),
    .pll_locked  (pll_locked),
    .pll_reset   (pll_reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_sel     (req_sel),
    .req_clk1_on (req_clk1_on),
    .req_clk3_on (req_clk3_on),
    .clk1_sel    (clk1_sel),
    .clk1_en     (clk1_en),
    .clk3_en     (clk3_en),
    .busy        (busy),
    .done        (done),
    .lock_lost   (lock_lost)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Waits for req_ready, then presents one request for exactly one accept edge.
  task automatic send_req(input logic s, input logic e1, input logic e3, output bit ok);
    int w = 0;
    while (req_ready !== 1'b1 && w < 100) begin
      @(negedge clk_src);
      w++;
    end
    ok = (req_ready === 1'b1);
    req_sel = s;
    req_clk1_on = e1;
    req_clk3_on = e3;
    req_valid = ok;
    @(negedge clk_src);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    int   hi, cyc, dones;
    exp_t e;
    pll_locked = 1'b1;
    @(negedge clk_src);
    rst_n_sys = 1'b0;
    repeat (2) @(negedge clk_src);
    n_checks++;
    if ({pll_reset, clk1_sel, clk1_en, clk3_en, req_ready, busy, done, lock_lost} !== 8'b1000_0100) begin
      n_fail++;
      $display("FAIL reset_values: got %b expected %b",
               {pll_reset, clk1_sel, clk1_en, clk3_en, req_ready, busy, done, lock_lost}, 8'b1000_0100);
    end
    sb.push_back(exp_t'(3'b000));
    rst_n_sys = 1'b1;
    hi = 0;
    while (pll_reset === 1'b1 && hi < 100) begin
      hi++;
      @(negedge clk_src);
    end
    n_checks++;
    if (hi !== 16) begin
      n_fail++;
      $display("FAIL pll_reset_len: got %0d expected %0d", hi, 16);
    end
    cyc = 0;
    dones = 0;
    while (req_ready !== 1'b1 && cyc < 200) begin
      if (done === 1'b1) begin
        dones++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL bringup_sb: got done expected no done");
        end else begin
          e = sb.pop_front();
          if ({clk1_sel, clk1_en, clk3_en} !== e) begin
            n_fail++;
            $display("FAIL bringup_cfg: got %b expected %b", {clk1_sel, clk1_en, clk3_en}, e);
          end
        end
      end
      @(negedge clk_src);
      cyc++;
    end
    n_checks++;
    if (req_ready !== 1'b1 || dones !== 1) begin
      n_fail++;
      $display("FAIL bringup_idle: got ready=%b dones=%0d expected ready=1 dones=1", req_ready, dones);
    end
    n_checks++;
    if ({clk1_sel, clk1_en, clk3_en, busy, lock_lost, done} !== 6'b000000) begin
      n_fail++;
      $display("FAIL idle_outputs: got %b expected %b",
               {clk1_sel, clk1_en, clk3_en, busy, lock_lost, done}, 6'b000000);
    end
  endtask

  task automatic test_no_switch();
    bit   ok;
    exp_t e;
    sb.push_back(exp_t'(3'b011));
    send_req(1'b0, 1'b1, 1'b1, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL nosw_accept: got ready=%b expected 1", req_ready);
    end
    @(negedge clk_src);
    n_checks++;
    if (done !== 1'b1 || req_ready !== 1'b0 || sb.size() == 0) begin
      n_fail++;
      $display("FAIL nosw_done: got done=%b ready=%b expected done=1 ready=0", done, req_ready);
    end else begin
      e = sb.pop_front();
      n_checks++;
      if ({clk1_sel, clk1_en, clk3_en} !== e) begin
        n_fail++;
        $display("FAIL nosw_cfg: got %b expected %b", {clk1_sel, clk1_en, clk3_en}, e);
      end
    end
    @(negedge clk_src);
    n_checks++;
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL nosw_ready: got ready=%b done=%b expected ready=1 done=0", req_ready, done);
    end
  endtask

  task automatic test_switch();
    bit   ok;
    exp_t e;
    logic exp_sel;
    sb.push_back(exp_t'(3'b111));
    send_req(1'b1, 1'b1, 1'b1, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL sw_accept: got ready=%b expected 1", req_ready);
    end
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk_src);
      exp_sel = (k >= 9);
      n_checks++;
      if ({clk1_sel, clk1_en, clk3_en, done} !== {exp_sel, 3'b010}) begin
        n_fail++;
        $display("FAIL sw_seq_T+%0d: got %b expected %b", k,
                 {clk1_sel, clk1_en, clk3_en, done}, {exp_sel, 3'b010});
      end
    end
    @(negedge clk_src);
    n_checks++;
    if (done !== 1'b1 || sb.size() == 0) begin
      n_fail++;
      $display("FAIL sw_done_T+25: got done=%b expected 1", done);
    end else begin
      e = sb.pop_front();
      n_checks++;
      if ({clk1_sel, clk1_en, clk3_en} !== e) begin
        n_fail++;
        $display("FAIL sw_cfg: got %b expected %b", {clk1_sel, clk1_en, clk3_en}, e);
      end
    end
    @(negedge clk_src);
    n_checks++;
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_ready_T+26: got ready=%b done=%b expected ready=1 done=0", req_ready, done);
    end
  endtask

  task automatic test_lock_loss();
    bit   ok;
    int   hi, w;
    exp_t e;
    // The request is aborted; the committed {1,1,1} is what comes back.
    sb.push_back(exp_t'(3'b111));
    send_req(1'b0, 1'b1, 1'b1, ok);
    repeat (9) @(negedge clk_src);
    n_checks++;
    if (!ok || clk1_sel !== 1'b0 || clk1_en !== 1'b0) begin
      n_fail++;
      $display("FAIL loss_in_switch: got sel=%b en1=%b expected sel=0 en1=0", clk1_sel, clk1_en);
    end
    pll_locked = 1'b0;
    repeat (2) @(negedge clk_src);
    n_checks++;
    if (clk3_en !== 1'b1 || lock_lost !== 1'b0) begin
      n_fail++;
      $display("FAIL loss_early: got en3=%b lost=%b expected en3=1 lost=0", clk3_en, lock_lost);
    end
    @(negedge clk_src);
    n_checks++;
    if ({clk1_en, clk3_en, lock_lost, pll_reset, clk1_sel, busy} !== 6'b001101) begin
      n_fail++;
      $display("FAIL loss_react: got %b expected %b",
               {clk1_en, clk3_en, lock_lost, pll_reset, clk1_sel, busy}, 6'b001101);
    end
    hi = 0;
    while (pll_reset === 1'b1 && hi < 100) begin
      hi++;
      if (hi == 4) pll_locked = 1'b1;
      @(negedge clk_src);
    end
    n_checks++;
    if (hi !== 16) begin
      n_fail++;
      $display("FAIL loss_pll_reset_len: got %0d expected %0d", hi, 16);
    end
    w = 0;
    while (done !== 1'b1 && w < 100) begin
      @(negedge clk_src);
      w++;
    end
    n_checks++;
    if (done !== 1'b1 || sb.size() == 0) begin
      n_fail++;
      $display("FAIL loss_restore_done: got done=%b expected 1", done);
    end else begin
      e = sb.pop_front();
      n_checks++;
      if ({clk1_sel, clk1_en, clk3_en} !== e || lock_lost !== 1'b1) begin
        n_fail++;
        $display("FAIL loss_restore_cfg: got %b lost=%b expected %b lost=1",
                 {clk1_sel, clk1_en, clk3_en}, lock_lost, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit   ok;
    int   cyc, dones;
    exp_t e;
    send_req(1'b0, 1'b1, 1'b1, ok);
    @(negedge clk_src);
    n_checks++;
    if (!ok || clk1_en !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_gate: got en1=%b busy=%b expected en1=0 busy=1", clk1_en, busy);
    end
    rst_n_sys = 1'b0;
    req_valid = 1'b1;
    req_sel = 1'b1;
    req_clk1_on = 1'b1;
    req_clk3_on = 1'b0;
    @(negedge clk_src);
    n_checks++;
    if ({pll_reset, clk1_sel, clk1_en, clk3_en, req_ready, busy, done, lock_lost} !== 8'b1000_0100) begin
      n_fail++;
      $display("FAIL rstmid_values: got %b expected %b",
               {pll_reset, clk1_sel, clk1_en, clk3_en, req_ready, busy, done, lock_lost}, 8'b1000_0100);
    end
    sb.push_back(exp_t'(3'b000));
    sb.push_back(exp_t'(3'b110));
    rst_n_sys = 1'b1;
    cyc = 0;
    dones = 0;
    while (req_ready !== 1'b1 && cyc < 200) begin
      if (done === 1'b1 && sb.size() != 0) begin
        dones++;
        e = sb.pop_front();
        n_checks++;
        if ({clk1_sel, clk1_en, clk3_en} !== e) begin
          n_fail++;
          $display("FAIL rstmid_bringup_cfg: got %b expected %b", {clk1_sel, clk1_en, clk3_en}, e);
        end
      end
      @(negedge clk_src);
      cyc++;
    end
    n_checks++;
    if (req_ready !== 1'b1 || dones !== 1 || clk1_en !== 1'b0 || clk3_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_held_req: got ready=%b dones=%0d en1=%b en3=%b expected 1 1 0 0",
               req_ready, dones, clk1_en, clk3_en);
    end
    @(negedge clk_src);
    req_valid = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 60) begin
      @(negedge clk_src);
      cyc++;
    end
    n_checks++;
    if (done !== 1'b1 || sb.size() == 0) begin
      n_fail++;
      $display("FAIL rstmid_req_done: got done=%b expected 1", done);
    end else begin
      e = sb.pop_front();
      n_checks++;
      if ({clk1_sel, clk1_en, clk3_en} !== e) begin
        n_fail++;
        $display("FAIL rstmid_req_cfg: got %b expected %b", {clk1_sel, clk1_en, clk3_en}, e);
      end
    end
  endtask

  task automatic test_glitch();
    int   w, k;
    exp_t e;
    pll_locked = 1'b1;
    @(negedge clk_src);
    rst_n_sys = 1'b0;
    @(negedge clk_src);
    sb.push_back(exp_t'(3'b000));
    rst_n_sys = 1'b1;
    w = 0;
    while (pll_reset !== 1'b0 && w < 100) begin
      @(negedge clk_src);
      w++;
    end
    repeat (10) @(negedge clk_src);
    pll_locked = 1'b0;
    @(negedge clk_src);
    pll_locked = 1'b1;
    k = 1;
    while (done !== 1'b1 && k < 100) begin
      @(negedge clk_src);
      k++;
    end
    // Filter must restart: 2 sync cycles plus 32 clean highs after the low.
    n_checks++;
    if (k < 34 || k > 40) begin
      n_fail++;
      $display("FAIL glitch_restart: got done at +%0d expected within +34..+40", k);
    end
    n_checks++;
    if (done !== 1'b1 || sb.size() == 0) begin
      n_fail++;
      $display("FAIL glitch_done: got done=%b expected 1", done);
    end else begin
      e = sb.pop_front();
      if ({clk1_sel, clk1_en, clk3_en, lock_lost} !== {e, 1'b0}) begin
        n_fail++;
        $display("FAIL glitch_cfg: got %b expected %b", {clk1_sel, clk1_en, clk3_en, lock_lost}, {e, 1'b0});
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_switch();
    test_switch();
    test_lock_loss();
    test_reset_mid();
    test_glitch();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
